wishbone_master: RTL
====================

WISHBONE_MASTER -- requirements
Module: wishbone_master

Interface
REQ-001 Parameter ADDR_WIDTH, default 2, Wishbone address width.
REQ-002 Parameter DATA_WIDTH, default 32, Wishbone data width.
REQ-003 Parameter TIMEOUT_CYCLES, default 255, max cycles CYC may stay high per transaction; legal range 2..65535.
REQ-004 i_clk  input  1  sole clock, all state updates on rising edge.
REQ-005 i_reset  input  1  asynchronous, active-high reset.
REQ-006 i_cmd_valid / o_cmd_ready  in/out  1/1  command handshake; transfer when both high at a rising edge.
REQ-007 i_cmd_we  input  1  1 = write, 0 = read.
REQ-008 i_cmd_addr / i_cmd_data  input  ADDR_WIDTH/DATA_WIDTH  command address and write data.
REQ-009 o_rsp_valid  output  1  one-cycle response strobe.
REQ-010 o_rsp_data / o_rsp_err  output  DATA_WIDTH/1  read data (zero on writes) and error flag.
REQ-011 o_wb_cyc, o_wb_stb, o_wb_we  output  1 each  Wishbone B4 pipelined master controls.
REQ-012 o_wb_addr / o_wb_odata  output  ADDR_WIDTH/DATA_WIDTH  bus address and write data.
REQ-013 i_wb_ack, i_wb_stall, i_wb_err  input  1 each  slave responses.
REQ-014 i_wb_idata  input  DATA_WIDTH  slave read data.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, RESP; exactly one outstanding transaction.
REQ-016 o_cmd_ready SHALL be high only in IDLE; accepted command registers addr/we/data and moves to REQ next cycle.
REQ-017 In REQ, o_wb_cyc=1 and o_wb_stb=1 with registered addr/we/data, held stable while i_wb_stall=1.
REQ-018 REQ with i_wb_stall=0 at an edge: request taken; stb drops next cycle, cyc stays high, go to WAIT.
REQ-019 i_wb_ack or i_wb_err sampled while cyc=1 (REQ with stall=0, or WAIT) SHALL end the cycle: cyc=0 next cycle, go to RESP.
REQ-020 Ack in same cycle as stall=0 acceptance SHALL skip WAIT and go directly to RESP.
REQ-021 Simultaneous ack and err: err wins, o_rsp_err=1.
REQ-022 RESP: o_rsp_valid=1 for exactly one cycle; o_rsp_data = i_wb_idata captured on ack for reads, 0 for writes or errors; then IDLE.
REQ-023 Minimum latency, zero stall, ack one cycle after stb: command accept -> o_rsp_valid = 3 cycles.
REQ-024 i_wb_ack/i_wb_err SHALL be ignored while cyc=0.
REQ-025 o_wb_stb SHALL never be high while o_wb_cyc is low.

Reset
REQ-026 i_reset asserted SHALL force IDLE immediately; o_wb_cyc, o_wb_stb, o_wb_we, o_rsp_valid, o_rsp_err = 0; o_wb_addr, o_wb_odata, o_rsp_data = 0; o_cmd_ready = 0 during reset, 1 first cycle after release.
REQ-027 Reset mid-transaction SHALL abort without response; late ack after release ignored per REQ-024.

Configuration
REQ-028 Macro WISHBONE_MASTER_TIMEOUT_EN defined: cycle counter runs while cyc=1; reaching TIMEOUT_CYCLES without ack/err forces cyc=stb=0 and RESP with o_rsp_err=1, o_rsp_data=0.
REQ-029 Macro undefined: no counter; master waits indefinitely for ack/err.

Structure
REQ-030 Shared package wishbone_pkg SHALL hold FSM state encodings and default ADDR/DATA widths, shared with the slave side.
REQ-031 Timeout counter SHALL be sub-module wb_timeout_counter (start, clear, expired), instantiated only under WISHBONE_MASTER_TIMEOUT_EN.

Verification
REQ-032 Write addr=1 data=0x00000001, slave acks next cycle -> one stb cycle, o_rsp_valid 3 cycles after accept, o_rsp_err=0, o_rsp_data=0.
REQ-033 Read addr=2, stall high 4 cycles, ack with idata=0xDEADBEEF -> stb high 5 cycles with stable addr, o_rsp_data=0xDEADBEEF.
REQ-034 Read with ack and err same cycle -> o_rsp_err=1, o_rsp_data=0.
REQ-035 TIMEOUT_EN, TIMEOUT_CYCLES=8, slave never responds -> cyc drops after 8 cycles, o_rsp_err=1; without macro cyc stays high 100+ cycles.
REQ-036 i_reset pulsed while in WAIT -> cyc/stb low immediately, no o_rsp_valid, stray ack afterwards ignored, next command completes normally.
REQ-037 Back-to-back commands with i_cmd_valid held high -> second accepted cycle after first RESP, no overlapping stb.

Source files
------------

// File: rtl/wishbone_pkg.sv
// Shared Wishbone definitions: master FSM state encoding and default bus widths.
// The slave side imports the same package so both ends agree on the widths.
package wishbone_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 2;
  localparam int unsigned WB_DATA_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// Bus-cycle watchdog: counts cycles while 'start' is high and flags 'expired'
// in the TIMEOUT_CYCLES-th consecutive cycle. 'clear' returns it to zero.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic start,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count;

  // Count active cycles; hold at the terminal value until cleared.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (start && !expired) begin
      count <= count + CW'(1);
    end
  end

  assign expired = start && (count == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/wishbone_master.sv
// Single-outstanding Wishbone B4 pipelined master.
// Command in (valid/ready), one bus transaction, one-cycle response strobe out.
// Optional bus watchdog enabled by defining WISHBONE_MASTER_TIMEOUT_EN.
module wishbone_master
  import wishbone_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH     = WB_DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_we,
  input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
  input  logic [DATA_WIDTH-1:0] i_cmd_data,
  output logic                  o_rsp_valid,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_err,
  output logic                  o_wb_cyc,
  output logic                  o_wb_stb,
  output logic                  o_wb_we,
  output logic [ADDR_WIDTH-1:0] o_wb_addr,
  output logic [DATA_WIDTH-1:0] o_wb_odata,
  input  logic                  i_wb_ack,
  input  logic                  i_wb_stall,
  input  logic                  i_wb_err,
  input  logic [DATA_WIDTH-1:0] i_wb_idata
);

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("wishbone_master: TIMEOUT_CYCLES must be in 2..65535");
  end

  wb_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  we_q;
  logic [DATA_WIDTH-1:0] rsp_data_q;
  logic                  rsp_err_q;
  logic                  cmd_accept;
  logic                  bus_live;
  logic                  bus_end;
  logic                  timeout_hit;

  assign cmd_accept = (state_q == ST_IDLE) && i_cmd_valid;
  // Slave responses only count once the strobe has been taken (or afterwards).
  assign bus_live   = ((state_q == ST_REQ) && !i_wb_stall) || (state_q == ST_WAIT);
  assign bus_end    = bus_live && (i_wb_ack || i_wb_err);

`ifdef WISHBONE_MASTER_TIMEOUT_EN
  wb_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .start   (o_wb_cyc),
    .clear   (!o_wb_cyc),
    .expired (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // State register; reset aborts any transaction in flight.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a real slave response beats a simultaneous timeout.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (i_cmd_valid) state_d = ST_REQ;
      ST_REQ: begin
        if (bus_end || timeout_hit) state_d = ST_RESP;
        else if (!i_wb_stall)       state_d = ST_WAIT;
      end
      ST_WAIT: if (bus_end || timeout_hit) state_d = ST_RESP;
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Command capture and response capture.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      addr_q     <= '0;
      data_q     <= '0;
      we_q       <= 1'b0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      if (cmd_accept) begin
        addr_q <= i_cmd_addr;
        data_q <= i_cmd_data;
        we_q   <= i_cmd_we;
      end
      if (bus_end) begin
        rsp_err_q  <= i_wb_err;
        rsp_data_q <= (i_wb_err || we_q) ? '0 : i_wb_idata;
      end else if (timeout_hit) begin
        rsp_err_q  <= 1'b1;
        rsp_data_q <= '0;
      end
    end
  end

  // Ready is masked by reset directly so it reads low while reset is held.
  assign o_cmd_ready = (state_q == ST_IDLE) && !i_reset;
  assign o_wb_cyc    = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign o_wb_stb    = (state_q == ST_REQ);
  assign o_wb_we     = we_q;
  assign o_wb_addr   = addr_q;
  assign o_wb_odata  = data_q;
  assign o_rsp_valid = (state_q == ST_RESP);
  assign o_rsp_data  = rsp_data_q;
  assign o_rsp_err   = rsp_err_q;

endmodule
